// File: rtl/mem_a_skew.sv
// rtl/mem_a_skew.sv - operand-A buffer streaming a DIM x DIM matrix column-wise with diagonal skew
// Row i is a DIM+i deep shift chain; the i leading zeros it holds after a write produce the skew.

module mem_a_skew #(
    parameter int BITS_AB = 8,
    parameter int DIM     = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          WrEn,
    input  logic signed [BITS_AB-1:0]     Ain  [DIM],
    input  logic        [$clog2(DIM)-1:0] Arow,
    output logic signed [BITS_AB-1:0]     Aout [DIM]
);

    localparam int AW = $clog2(DIM);

    for (genvar gi = 0; gi < DIM; gi++) begin : g_row
        localparam int            L   = DIM + gi;
        localparam logic [AW-1:0] ROW = AW'(gi);

        logic signed [BITS_AB-1:0] r_q [L];
        logic                      w_wr;

        // Out-of-range Arow (non power-of-two DIM) matches no row and is dropped.
        assign w_wr = WrEn && (Arow == ROW);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int p = 0; p < L; p++) begin
                    r_q[p] <= '0;
                end
            end else if (w_wr) begin
                for (int p = 0; p < L; p++) begin
                    r_q[p] <= '0;
                end
                for (int j = 0; j < DIM; j++) begin
                    r_q[gi+j] <= Ain[j];
                end
            end else if (en) begin
                for (int p = 0; p < L-1; p++) begin
                    r_q[p] <= r_q[p+1];
                end
                r_q[L-1] <= '0;
            end
        end

        assign Aout[gi] = r_q[0];
    end

endmodule

// File: tb/tb_mem_a_skew.sv
// tb/tb_mem_a_skew.sv - scoreboard bench for mem_a_skew: reset, fill, hold, overwrite, write-during-shift, mid-stream reset

module tb_mem_a_skew;

    localparam int BITS_AB = 8;
    localparam int DIM     = 8;

    logic                      clk;
    logic                      clk_run;
    logic                      rst_n;
    logic                      en;
    logic                      WrEn;
    logic signed [BITS_AB-1:0] ain  [DIM];
    logic        [2:0]         arow;
    logic signed [BITS_AB-1:0] aout [DIM];

    int a [DIM][DIM];
    int b [DIM];
    logic [DIM*BITS_AB-1:0] exp_q [$];
    int n_checks;
    int n_fails;

    mem_a_skew #(.BITS_AB(BITS_AB), .DIM(DIM)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .WrEn (WrEn),
        .Ain  (ain),
        .Arow (arow),
        .Aout (aout)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    function automatic logic [DIM*BITS_AB-1:0] stream_exp(input int k);
        logic [DIM*BITS_AB-1:0] v;
        v = '0;
        for (int i = 0; i < DIM; i++) begin
            if (k >= i && k <= i + DIM - 1) v[i*BITS_AB +: BITS_AB] = 8'(a[i][k-i]);
        end
        return v;
    endfunction

    task automatic push_exp(input logic [DIM*BITS_AB-1:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag);
        logic [DIM*BITS_AB-1:0] e;
        logic signed [BITS_AB-1:0] ev;
        n_checks++;
        assert (exp_q.size() > 0) else begin
            n_fails++;
            $error("FAIL %s scoreboard empty observed 0 entries expected 1", tag);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int i = 0; i < DIM; i++) begin
                ev = e[i*BITS_AB +: BITS_AB];
                n_checks++;
                assert (aout[i] === ev) else begin
                    n_fails++;
                    $error("FAIL %s lane %0d observed %0d expected %0d", tag, i, aout[i], ev);
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_row(input int r, input int base, input int stp);
        WrEn = 1'b1;
        arow = 3'(r);
        for (int j = 0; j < DIM; j++) begin
            ain[j]  = 8'(base + j * stp);
            a[r][j] = base + j * stp;
        end
        step();
        WrEn = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        clk_run  = 1'b0;
        rst_n    = 1'b1;
        en       = 1'b0;
        WrEn     = 1'b0;
        arow     = '0;
        for (int j = 0; j < DIM; j++) ain[j] = '0;

        // reset with the clock stopped
        #1 rst_n = 1'b0;
        push_exp('0);
        #1 check("reset_async");
        rst_n = 1'b1;
        push_exp('0);
        #1 check("reset_release");
        clk_run = 1'b1;

        // fill, hold, stream
        for (int r = 0; r < DIM; r++) load_row(r, 1, 1);
        push_exp(stream_exp(0));
        check("fill_k0");
        for (int h = 0; h < 5; h++) begin
            push_exp(stream_exp(0));
            step();
            check("hold");
        end
        en = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            push_exp(stream_exp(k));
            step();
            check($sformatf("stream_k%0d", k));
        end
        push_exp('0);
        step();
        check("drained");
        en = 1'b0;

        // overwrite row 3: -128 then 5
        for (int r = 0; r < DIM; r++) load_row(r, 1, 1);
        load_row(3, -128, 0);
        load_row(3, 5, 0);
        push_exp(stream_exp(0));
        check("ovw_k0");
        en = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            push_exp(stream_exp(k));
            step();
            check($sformatf("ovw_k%0d", k));
        end
        en = 1'b0;

        // write during shift on row 2
        for (int r = 0; r < DIM; r++) load_row(r, r * 8 + 1, 1);
        a[0][0] = -128;
        WrEn = 1'b1; arow = 3'd0;
        for (int j = 0; j < DIM; j++) ain[j] = 8'(a[0][j]);
        step();
        WrEn = 1'b0;
        push_exp(stream_exp(0));
        check("wds_k0");
        en = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            push_exp(stream_exp(k));
            step();
            check($sformatf("wds_k%0d", k));
        end
        for (int j = 0; j < DIM; j++) begin
            b[j]   = 100 + j;
            ain[j] = 8'(b[j]);
        end
        for (int m = 0; m <= 12; m++) begin
            logic [DIM*BITS_AB-1:0] v;
            WrEn = (m == 0);
            arow = 3'd2;
            v = stream_exp(3 + m);
            v[2*BITS_AB +: BITS_AB] = (m >= 2 && m <= 9) ? 8'(b[m-2]) : 8'd0;
            push_exp(v);
            step();
            check($sformatf("wds_m%0d", m));
        end
        WrEn = 1'b0;
        en   = 1'b0;

        // reset in the middle of a stream
        for (int r = 0; r < DIM; r++) load_row(r, 1, 1);
        en = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            push_exp(stream_exp(k));
            step();
            check($sformatf("mid_k%0d", k));
        end
        rst_n = 1'b0;
        push_exp('0);
        #1 check("mid_reset");
        step();
        rst_n = 1'b1;
        for (int s = 0; s < 3; s++) begin
            push_exp('0);
            step();
            check("after_reset");
        end
        en = 1'b0;

        n_checks++;
        assert (exp_q.size() == 0) else begin
            n_fails++;
            $error("FAIL scoreboard_leftover observed %0d expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
